gate_exerciser: RTL

//  Sequential stimulus generator and response checker for the basic two-input gate block.

---
 rtl/gate_exerciser.sv | 139 +++++++++++++
 1 files changed

// File: rtl/gate_exerciser.sv
// Self-test master for the two-input gate block: walks a/b through 00,01,10,11 for LOOPS passes
// and checks the seven gate outputs. Optional macro GATE_EXER_STOP_ON_FAIL_EN ends a run at the first failing check.
module gate_exerciser #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned LOOPS         = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       and_in,
   input  logic       or_in,
   input  logic       not_in,
   input  logic       nand_in,
   input  logic       nor_in,
   input  logic       xor_in,
   input  logic       xnor_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [6:0] err_vec
);

   localparam int unsigned CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
   localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [LOOP_W-1:0] LOOP_LAST  = LOOP_W'(LOOPS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [LOOP_W-1:0] loop_q;
   logic [1:0]        vec_q;
   logic [1:0]        vec_d;
   logic              a_q, b_q, busy_q, done_q, pass_q;
   logic [7:0]        err_count_q;
   logic [6:0]        err_vec_q;

   logic [6:0] exp_c, obs_c, mask_c;
   logic       last_c, stop_c;

   // Expected gate responses for the vector currently driven, bit order {xnor,xor,nor,nand,not,or,and}
   always_comb begin
      exp_c  = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q), ~a_q, a_q | b_q, a_q & b_q};
      obs_c  = {xnor_in, xor_in, nor_in, nand_in, not_in, or_in, and_in};
      mask_c = exp_c ^ obs_c;
      last_c = (vec_q == 2'd3) && (loop_q == LOOP_LAST);
      vec_d  = vec_q + 2'd1;
`ifdef GATE_EXER_STOP_ON_FAIL_EN
      stop_c = |mask_c;
`else
      stop_c = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         loop_q      <= '0;
         vec_q       <= '0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_count_q <= '0;
         err_vec_q   <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  err_count_q <= '0;
                  err_vec_q   <= '0;
                  pass_q      <= 1'b0;
                  vec_q       <= '0;
                  loop_q      <= '0;
                  a_q         <= 1'b0;
                  b_q         <= 1'b0;
                  cnt_q       <= CNT_RELOAD;
                  busy_q      <= 1'b1;
                  state_q     <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt_q == '0) begin
                  state_q <= S_CHECK;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_CHECK: begin
               err_vec_q <= err_vec_q | mask_c;
               if ((|mask_c) && (err_count_q != 8'hFF)) begin
                  err_count_q <= err_count_q + 8'd1;
               end
               if (last_c || stop_c) begin
                  state_q <= S_DONE;
               end else begin
                  // Vector 3 wraps back to 0 and opens the next pass
                  vec_q <= vec_d;
                  if (vec_q == 2'd3) begin
                     loop_q <= loop_q + LOOP_W'(1);
                  end
                  a_q     <= vec_d[1];
                  b_q     <= vec_d[0];
                  cnt_q   <= CNT_RELOAD;
                  state_q <= S_SETTLE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               pass_q  <= (err_count_q == 8'd0);
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_count_q;
   assign err_vec   = err_vec_q;

endmodule
